display_decoder: RTL

Receive-side counterpart of the board display driver: samples the multiplexed anode and segment lines (`an`, `dec_ddp`) and rebuilds the eight 6-bit digit words `d1`..`d8` the driver was given. It is used as a loopback monitor in simulation and on-board self-test, so bench and checker logic can compare digit words directly instead of segment patterns. It sits beside the display driver on the same clock and sees only its outputs.

---
 rtl/display_pkg.sv | 29 ++
 rtl/seg7_to_hex.sv | 26 ++
 rtl/display_decoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and glyph table for the 7-segment loopback decoder.
// Glyphs are active-low, bit 6 = segment a down to bit 0 = segment g.
package display_pkg;

    typedef struct packed {
        logic       en;
        logic [3:0] value;
        logic       dp;
    } digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic logic [3:0] count_low(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            if (!v[i]) n = n + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of an active-low 7-segment pattern.
// valid = one of the 16 hex glyphs, blank = all segments off.
module seg7_to_hex
    import display_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic       blank_o,
    output logic [3:0] value_o
);

    // search the glyph table; no match leaves valid low
    always_comb begin
        valid_o = 1'b0;
        value_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == GLYPH[i]) begin
                valid_o = 1'b1;
                value_o = 4'(i);
            end
        end
    end

    assign blank_o = (seg_i == SEG_BLANK);

endmodule

// File: rtl/display_decoder.sv
// Rebuilds the eight digit words from multiplexed anode/segment lines.
// Define DISPLAY_DECODER_ERR_EN to add the sticky err output.
module display_decoder
    import display_pkg::*;
#(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 400000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] an,
    input  logic [7:0] dec_ddp,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8,
    output logic       frame_valid
`ifdef DISPLAY_DECODER_ERR_EN
    ,
    output logic       err
`endif
);

    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    SETTLE_C = 8'(SETTLE);
    localparam logic [TW-1:0] TMO_C    = TW'(TIMEOUT);

    logic [7:0]    s_an_q;
    logic [7:0]    s_seg_q;
    logic [15:0]   prev_q;
    logic [7:0]    cnt_q, cnt_d;
    logic          hit_q, hit_d;
    digit_t        dig_q [8];
    digit_t        dig_d [8];
    logic [TW-1:0] tmo_q [8];
    logic [TW-1:0] tmo_d [8];
    logic [7:0]    mask_q, mask_d;
    logic          fv_q, fv_d;

    logic [7:0] cap_an;
    logic [7:0] cap_seg;
    logic [3:0] lows_w;
    logic       valid_w, blank_w;
    logic [3:0] value_w;
    logic       upd_w;
    digit_t     new_w;

    // prev_q holds the settled sample when hit_q fires, so decode it
    assign cap_an  = prev_q[15:8];
    assign cap_seg = prev_q[7:0];
    assign lows_w  = count_low(cap_an);

    seg7_to_hex u_dec (
        .seg_i   (cap_seg[7:1]),
        .valid_o (valid_w),
        .blank_o (blank_w),
        .value_o (value_w)
    );

    assign upd_w = hit_q && (lows_w == 4'd1) && (valid_w || blank_w);
    assign new_w = {valid_w, value_w, ~cap_seg[0]};

    // input registers, stability counter and capture strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            s_an_q  <= '1;
            s_seg_q <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            s_an_q  <= an;
            s_seg_q <= dec_ddp;
            prev_q  <= {s_an_q, s_seg_q};
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
        end
    end

    // count identical samples; strobe once when SETTLE is first reached
    always_comb begin
        if ({s_an_q, s_seg_q} != prev_q) begin
            cnt_d = 8'd1;
        end else if (cnt_q == SETTLE_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        hit_d = (cnt_d == SETTLE_C) && (cnt_q != SETTLE_C);
    end

    // digit words, timeout counters and frame mask state
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                dig_q[i] <= '0;
                tmo_q[i] <= '0;
            end
            mask_q <= '0;
            fv_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                dig_q[i] <= dig_d[i];
                tmo_q[i] <= tmo_d[i];
            end
            mask_q <= mask_d;
            fv_q   <= fv_d;
        end
    end

    // timeout blanking first, then a capture overrides it
    always_comb begin
        logic [7:0] hit_bits;
        hit_bits = '0;
        fv_d     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dig_d[i] = dig_q[i];
            if (tmo_q[i] == TMO_C) begin
                tmo_d[i] = tmo_q[i];
                dig_d[i] = '0;
            end else begin
                tmo_d[i] = tmo_q[i] + TW'(1);
            end
            if (upd_w && !cap_an[7-i]) begin
                dig_d[i]    = new_w;
                tmo_d[i]    = '0;
                hit_bits[i] = 1'b1;
            end
        end
        if ((mask_q | hit_bits) == 8'hFF) begin
            fv_d   = 1'b1;
            mask_d = '0;
        end else begin
            mask_d = mask_q | hit_bits;
        end
    end

    assign d1 = dig_q[0];
    assign d2 = dig_q[1];
    assign d3 = dig_q[2];
    assign d4 = dig_q[3];
    assign d5 = dig_q[4];
    assign d6 = dig_q[5];
    assign d7 = dig_q[6];
    assign d8 = dig_q[7];
    assign frame_valid = fv_q;

`ifdef DISPLAY_DECODER_ERR_EN
    logic err_q;
    logic bad_w;

    assign bad_w = hit_q && ((lows_w > 4'd1) ||
                   ((lows_w == 4'd1) && !valid_w && !blank_w));

    // sticky error flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | bad_w;
        end
    end

    assign err = err_q;
`endif

endmodule
